// File: rtl/stump_mem_arbiter_pkg.sv
// Shared definitions for the Stump memory arbiter: FSM states, owner codes
// and the starvation counter width helper.
package stump_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DMA  = 2'b01,
    ST_ACK  = 2'b10
  } arb_state_e;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_DMA  = 2'b10;

  // Counter must hold 0..limit and is never narrower than 2 bits.
  function automatic int unsigned cnt_width(input int unsigned limit);
    int unsigned w;
    w = $clog2(limit + 1);
    return (w < 2) ? 2 : w;
  endfunction

endpackage

// File: rtl/stump_mem_arbiter.sv
// Single-port memory arbiter between the Stump CPU and a DMA/debug port.
// Define STUMP_ARB_FAIRNESS_EN to build the DMA starvation counter / forced grant.
module stump_mem_arbiter
  import stump_mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ren,
  input  logic        cpu_wen,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_wen,
  input  logic [15:0] dma_addr,
  input  logic [15:0] dma_wdata,
  output logic [15:0] dma_rdata,
  output logic        dma_ack,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_ren,
  output logic        mem_wen,
  input  logic [15:0] mem_rdata,
  output logic [1:0]  owner
);

  arb_state_e  state_q;
  logic        dma_wen_q;
  logic [15:0] dma_addr_q;
  logic [15:0] dma_wdata_q;
  logic [15:0] dma_rdata_q;
  logic        dma_ack_q;
  logic        cpu_req;
  logic        grant_dma;

  assign cpu_req = cpu_ren | cpu_wen;

`ifdef STUMP_ARB_FAIRNESS_EN
  localparam int unsigned CW = cnt_width(STARVE_LIMIT);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_q, starve_d;

  assign grant_dma = dma_req && (!cpu_req || (starve_q == LIMIT));

  always_comb begin
    starve_d = starve_q;
    if (state_q == ST_IDLE) begin
      if (grant_dma)
        starve_d = '0;
      else if (dma_req && cpu_req && (starve_q != LIMIT))
        starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end
`else
  // The limit only has meaning when the fairness counter is compiled in.
  logic unused_starve_limit;
  assign unused_starve_limit = ^STARVE_LIMIT;
  assign grant_dma = dma_req && !cpu_req;
`endif

  // The DMA request is captured at grant so a request withdrawn during the
  // DMA cycle still completes with the committed address/data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      dma_wen_q   <= 1'b0;
      dma_addr_q  <= '0;
      dma_wdata_q <= '0;
      dma_rdata_q <= '0;
      dma_ack_q   <= 1'b0;
    end else begin
      dma_ack_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (grant_dma) begin
            state_q     <= ST_DMA;
            dma_wen_q   <= dma_wen;
            dma_addr_q  <= dma_addr;
            dma_wdata_q <= dma_wdata;
          end
        end
        ST_DMA: begin
          if (!dma_wen_q) dma_rdata_q <= mem_rdata;
          dma_ack_q <= 1'b1;
          state_q   <= ST_ACK;
        end
        ST_ACK:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    owner     = OWN_NONE;
    cpu_stall = 1'b0;
    if (!rst) begin
      if (state_q == ST_DMA) begin
        mem_addr  = dma_addr_q;
        mem_wdata = dma_wdata_q;
        mem_wen   = dma_wen_q;
        mem_ren   = !dma_wen_q;
        owner     = OWN_DMA;
        cpu_stall = cpu_req;
      end else if (cpu_req) begin
        mem_wen = cpu_wen;
        mem_ren = cpu_ren && !cpu_wen;
        owner   = OWN_CPU;
      end
    end
  end

  assign cpu_rdata = mem_rdata;
  assign dma_rdata = dma_rdata_q;
  assign dma_ack   = dma_ack_q;

endmodule

// File: tb/tb_stump_mem_arbiter.sv
// Scoreboard bench for stump_mem_arbiter: DMA results are predicted from a
// shadow memory; a negedge monitor checks every ack and the per-cycle port rules.
module tb_stump_mem_arbiter;
  import stump_mem_arbiter_pkg::*;

  localparam int unsigned LIMIT = 3;
`ifdef STUMP_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_ren, cpu_wen;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dma_req, dma_wen;
  logic [15:0] dma_addr, dma_wdata, dma_rdata;
  logic        dma_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ren, mem_wen;
  logic [1:0]  owner;

  logic [15:0] phys_mem [0:65535];
  logic [15:0] ref_mem  [0:65535];

  typedef struct {
    bit          w;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] exp;
  } txn_t;
  txn_t sb_q[$];

  int tests = 0;
  int fails = 0;
  int ack_count = 0;
  int cyc = 0;

  stump_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .cpu_ren(cpu_ren), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_wen(dma_wen), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ren(mem_ren),
    .mem_wen(mem_wen), .mem_rdata(mem_rdata), .owner(owner)
  );

  always #5 clk = ~clk;

  assign mem_rdata = phys_mem[mem_addr];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_wen) phys_mem[mem_addr] = mem_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: idle, 1: always requesting, 2: random (incl. illegal read+write)
  task automatic drive_cpu(input int mode);
    int r;
    if (mode == 0)      r = 0;
    else if (mode == 1) r = $urandom_range(1, 3);
    else                r = $urandom_range(0, 3);
    cpu_ren   = (r == 1) || (r == 3);
    cpu_wen   = (r == 2) || (r == 3);
    cpu_addr  = 16'($urandom_range(0, 255));
    cpu_wdata = 16'($urandom);
  endtask

  // Issue one DMA access from an IDLE cycle and follow it through DMA and ACK.
  task automatic dma_txn(input bit w, input logic [15:0] a, input logic [15:0] d,
                         input int mode, input bit maybe_drop);
    txn_t t;
    int   k;
    int   m;
    bit   granted;
    bit   creq;
    t.w = w; t.a = a; t.d = d; t.exp = ref_mem[a];
    if (w) ref_mem[a] = d;
    sb_q.push_back(t);
    dma_wen = w; dma_addr = a; dma_wdata = d; dma_req = 1'b1;
    k = 0;
    granted = 1'b0;
    for (int i = 0; i < 300 && !granted; i++) begin
      m = (mode == 1 && i >= 20) ? 0 : mode;
      drive_cpu(m);
      creq = cpu_ren | cpu_wen;
      granted = !creq || (FAIR && k == int'(LIMIT));
      @(negedge clk);
      if (!granted) begin
        check("wait_cpu_owner", 32'(owner), 32'(OWN_CPU));
        check("wait_no_ack", 32'(dma_ack), 32'd0);
        k++;
      end
      step();
    end
    if (!granted) begin
      tests++; fails++;
      $display("FAIL dma_grant_timeout: no grant after 300 cycles, addr 0x%0h", a);
      dma_req = 1'b0;
      void'(sb_q.pop_back());
      return;
    end
    drive_cpu(mode == 1 ? 1 : mode);
    if (maybe_drop && $urandom_range(0, 1) == 1) dma_req = 1'b0;
    @(negedge clk);
    check("dma_owner", 32'(owner), 32'(OWN_DMA));
    check("dma_mem_addr", 32'(mem_addr), 32'(a));
    check("dma_mem_wen", 32'(mem_wen), 32'(w));
    check("dma_mem_ren", 32'(mem_ren), 32'(!w));
    if (w) check("dma_mem_wdata", 32'(mem_wdata), 32'(d));
    check("dma_cycle_no_ack", 32'(dma_ack), 32'd0);
    step();
    dma_req = 1'b0;
    drive_cpu(mode == 1 ? 1 : mode);
    @(negedge clk);
    check("ack_cycle", 32'(dma_ack), 32'd1);
    step();
  endtask

  // Monitor: pops the scoreboard on every ack and checks the port rules each cycle.
  logic [15:0] last_rd = '0;
  bit          prev_ack = 1'b0;
  initial begin
    txn_t t;
    bit   creq;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_rd  = '0;
        prev_ack = 1'b0;
      end else begin
        creq = cpu_ren | cpu_wen;
        check("strobe_exclusive", 32'(mem_ren & mem_wen), 32'd0);
        check("cpu_rdata_pass", 32'(cpu_rdata), 32'(mem_rdata));
        case (owner)
          OWN_CPU: begin
            check("cpu_owner_req", 32'(creq), 32'd1);
            check("cpu_mem_addr", 32'(mem_addr), 32'(cpu_addr));
            check("cpu_mem_wdata", 32'(mem_wdata), 32'(cpu_wdata));
            check("cpu_mem_wen", 32'(mem_wen), 32'(cpu_wen));
            check("cpu_mem_ren", 32'(mem_ren), 32'(cpu_ren & ~cpu_wen));
            check("cpu_no_stall", 32'(cpu_stall), 32'd0);
          end
          OWN_DMA: check("dma_stall", 32'(cpu_stall), 32'(creq));
          OWN_NONE: begin
            check("none_no_req", 32'(creq), 32'd0);
            check("none_strobes", 32'({mem_ren, mem_wen}), 32'd0);
            check("none_mem_addr", 32'(mem_addr), 32'(cpu_addr));
            check("none_mem_wdata", 32'(mem_wdata), 32'(cpu_wdata));
            check("none_no_stall", 32'(cpu_stall), 32'd0);
          end
          default: check("owner_encoding", 32'(owner), 32'(OWN_NONE));
        endcase
        if (dma_ack) begin
          ack_count++;
          check("ack_single_cycle", 32'(prev_ack), 32'd0);
          if (sb_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL ack_unexpected: dma_ack=1 with no access outstanding");
          end else begin
            t = sb_q.pop_front();
            if (t.w) begin
              check("dma_write_mem", 32'(phys_mem[t.a]), 32'(t.d));
              check("dma_rdata_hold", 32'(dma_rdata), 32'(last_rd));
            end else begin
              check("dma_rdata", 32'(dma_rdata), 32'(t.exp));
              last_rd = t.exp;
            end
          end
        end
        prev_ack = dma_ack;
      end
    end
  end

  initial begin
    int base;
    int last_cyc;
    bit seen;
    for (int i = 16'h0200; i < 16'h0400; i++) begin
      phys_mem[i] = 16'($urandom);
      ref_mem[i]  = phys_mem[i];
    end
    phys_mem[16'h0200] = 16'hBEEF;
    ref_mem[16'h0200]  = 16'hBEEF;

    rst = 1'b1;
    cpu_ren = 1'b1; cpu_wen = 1'b0; cpu_addr = 16'h0010; cpu_wdata = '0;
    dma_req = 1'b0; dma_wen = 1'b0; dma_addr = '0; dma_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_cpu_stall", 32'(cpu_stall), 32'd0);
    check("rst_strobes", 32'({mem_ren, mem_wen}), 32'd0);
    check("rst_owner", 32'(owner), 32'(OWN_NONE));
    check("rst_dma_ack", 32'(dma_ack), 32'd0);
    check("rst_dma_rdata", 32'(dma_rdata), 32'd0);
    step();
    rst = 1'b0;
    cpu_ren = 1'b0;
    step();

    // Lone CPU read is granted in the same cycle.
    cpu_ren = 1'b1; cpu_wen = 1'b0; cpu_addr = 16'h0010;
    #1;
    check("cpu_rd_ren", 32'(mem_ren), 32'd1);
    check("cpu_rd_addr", 32'(mem_addr), 32'h0010);
    check("cpu_rd_owner", 32'(owner), 32'(OWN_CPU));
    check("cpu_rd_stall", 32'(cpu_stall), 32'd0);
    step();
    cpu_ren = 1'b0;
    step();

    dma_txn(1'b0, 16'h0200, 16'h0000, 0, 1'b0);
    dma_txn(1'b1, 16'h0300, 16'h1234, 1, 1'b0);
    check("mem_0300", 32'(phys_mem[16'h0300]), 32'h1234);

    // Reset in the middle of a DMA cycle aborts the access.
    drive_cpu(0);
    dma_wen = 1'b0; dma_addr = 16'h0201; dma_req = 1'b1;
    step();
    @(negedge clk);
    check("pre_rst_owner", 32'(owner), 32'(OWN_DMA));
    #2 rst = 1'b1;
    #1;
    check("async_rst_ack", 32'(dma_ack), 32'd0);
    check("async_rst_rdata", 32'(dma_rdata), 32'd0);
    check("async_rst_owner", 32'(owner), 32'(OWN_NONE));
    dma_req = 1'b0;
    base = ack_count;
    step();
    step();
    rst = 1'b0;
    repeat (6) step();
    check("no_ack_after_rst", 32'(ack_count), 32'(base));

    // Continuously held request with an idle CPU: IDLE, DMA, ACK repeating.
    drive_cpu(0);
    dma_wen = 1'b0; dma_addr = 16'h0205; dma_req = 1'b1;
    for (int n = 0; n < 4; n++)
      sb_q.push_back('{w: 1'b0, a: 16'h0205, d: 16'h0000, exp: ref_mem[16'h0205]});
    last_cyc = 0;
    for (int n = 0; n < 4; n++) begin
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
        @(negedge clk);
        seen = dma_ack;
      end
      if (!seen) begin
        tests++; fails++;
        $display("FAIL b2b_ack_timeout: access %0d not acked within 10 cycles", n);
      end else if (n > 0) begin
        check("b2b_spacing", 32'(cyc - last_cyc), 32'd3);
      end
      last_cyc = cyc;
    end
    #1 dma_req = 1'b0;
    base = ack_count;
    repeat (6) step();
    check("b2b_no_extra_ack", 32'(ack_count), 32'(base));
    sb_q.delete();

    // Randomised traffic with competing CPU requests.
    for (int n = 0; n < 40; n++) begin
      dma_txn(1'($urandom_range(0, 1)), 16'(16'h0200 + $urandom_range(0, 511)),
              16'($urandom), 2, 1'b1);
      repeat ($urandom_range(0, 2)) begin
        drive_cpu(2);
        step();
      end
    end
    drive_cpu(0);
    repeat (4) step();
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
